encoder_8_to_3_seq: RTL

ENCODER_8_TO_3_SEQ -- requirements
Module: encoder_8_to_3_seq

---
 rtl/encoder_8_to_3_seq.sv | 117 +++++++++++
 1 files changed

// File: rtl/encoder_8_to_3_seq.sv
`default_nettype none
// ============================================================================
// Module   : encoder_8_to_3_seq
// Brief    : Sequential 8-to-3 priority encoder with sticky pending requests,
//            valid/ready output handshake and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module encoder_8_to_3_seq #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       E,
    input  logic [7:0] D,
    input  logic       out_ready,
    output logic [2:0] A,
    output logic       out_valid,
    output logic       GS,
    output logic       OVF
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_ovf;

    logic [7:0] w_capture;
    logic [7:0] w_merged;
    logic [7:0] w_selSrc;
    logic [2:0] w_selIdx;
    logic       w_take;
    logic [7:0] w_clear;
    logic [7:0] w_presMask;
    logic       w_dup;
    logic [7:0] w_nextPending;

    function automatic logic [2:0] pickIndex(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        // Last match in scan order wins, so scan from the lowest-priority end.
        if (LOW_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    always_comb begin
        w_capture  = E ? 8'h00 : D;
        w_merged   = r_pending | w_capture;
        // IDLE serves only already-registered requests; an accept may chain
        // straight into a request arriving on the same edge.
        w_selSrc   = (r_state == ST_IDLE) ? r_pending : w_merged;
        w_selIdx   = pickIndex(w_selSrc);
        w_take     = (r_state == ST_IDLE) ? (r_pending != 8'h00)
                                          : (out_ready && (w_merged != 8'h00));
        w_clear    = w_take ? (8'h01 << w_selIdx) : 8'h00;
        w_presMask = r_valid ? (8'h01 << r_code) : 8'h00;
        w_dup      = |(w_capture & r_pending & ~w_clear & ~w_presMask);
        // Set-wins: a fresh request re-pends a bit cleared on the same edge.
        w_nextPending = (r_pending & ~w_clear) | w_capture;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 8'h00;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= w_nextPending;
            if (w_dup) r_ovf <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_code  <= w_selIdx;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (out_ready) begin
                        if (w_take) begin
                            r_code <= w_selIdx;
                        end else begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign A         = r_code;
    assign out_valid = r_valid;
    assign OVF       = r_ovf;
    assign GS        = (r_pending != 8'h00) | r_valid;

endmodule
`default_nettype wire
